// File: rtl/uart_pkg.sv
// Shared constants for the serial command receiver: frame tag and FSM encodings.
package uart_pkg;

  // Upper five bits of a valid header byte; the low three carry the opcode.
  localparam logic [4:0] CMD_TAG = 5'b10100;

  // Byte receiver states.
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Frame assembler states.
  localparam logic [1:0] AS_HDR = 2'd0;
  localparam logic [1:0] AS_OPA = 2'd1;
  localparam logic [1:0] AS_OPB = 2'd2;

  function automatic logic is_hdr(input logic [7:0] d);
    return d[7:3] == CMD_TAG;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchronizer, falling-edge start detect,
// mid-bit sampling, one-cycle byte_valid / frame_err strobes.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);
  import uart_pkg::*;

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic          sync1, rxs, rxs_d;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          stop_wait;   // bad stop seen, waiting for the line to go idle

  // Synchronizer plus one extra stage for falling-edge detection; all idle high.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  // Byte FSM: start qualify at half bit, then sample every full bit period.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      stop_wait  <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else if (!ena) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_wait  <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rxs_d && !rxs) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? RX_IDLE : RX_DATA;   // high at mid-start = glitch
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};          // LSB arrives first
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (stop_wait) begin
            if (rxs) begin
              stop_wait <= 1'b0;
              state     <= RX_IDLE;
            end
          end else if (cnt == LAST) begin
            cnt <= '0;
            if (rxs) begin
              byte_valid <= 1'b1;
              state      <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              stop_wait <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign data = shreg;
  assign busy = (state != RX_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// Serial command receiver: assembles header/A/B byte frames into a registered
// a/b/opcode update with a one-cycle cmd_valid strobe.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [2:0] opcode,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       hdr_err,
  output logic       busy
);
  import uart_pkg::*;

  localparam int            TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TW        = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

  logic [7:0]    rx_data;
  logic          byte_valid, byte_busy;
  logic [1:0]    as_state;
  logic [TW-1:0] tcnt;
  logic          commit;      // B latched; outputs load on the following edge
  logic [7:0]    a_p, b_p;
  logic [2:0]    op_p;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clock      (clock),
    .reset      (reset),
    .ena        (ena),
    .rx         (rx),
    .data       (rx_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (byte_busy)
  );

  // Assembler FSM with mid-frame inter-byte timeout; a byte beats a timeout.
  always_ff @(posedge clock) begin
    if (reset || !ena) begin
      as_state  <= AS_HDR;
      tcnt      <= '0;
      commit    <= 1'b0;
      cmd_valid <= 1'b0;
      hdr_err   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      hdr_err   <= 1'b0;
      if (commit) begin
        commit    <= 1'b0;
        cmd_valid <= 1'b1;
        as_state  <= AS_HDR;
        tcnt      <= '0;
      end else if (frame_err) begin
        as_state <= AS_HDR;
        tcnt     <= '0;
      end else if (byte_valid) begin
        tcnt <= '0;
        case (as_state)
          AS_HDR: begin
            if (is_hdr(rx_data)) as_state <= AS_OPA;
            else                 hdr_err  <= 1'b1;
          end
          AS_OPA:  as_state <= AS_OPB;
          AS_OPB:  commit   <= 1'b1;
          default: as_state <= AS_HDR;
        endcase
      end else if (as_state != AS_HDR) begin
        if (tcnt == TO_LAST) begin
          as_state <= AS_HDR;
          tcnt     <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  // Pending frame fields, captured as each byte is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_p <= '0;
      a_p  <= '0;
      b_p  <= '0;
    end else if (ena && byte_valid && !commit && !frame_err) begin
      case (as_state)
        AS_HDR:  op_p <= rx_data[2:0];
        AS_OPA:  a_p  <= rx_data;
        AS_OPB:  b_p  <= rx_data;
        default: ;
      endcase
    end
  end

  // Output registers: updated only on a completed frame, held across ena low.
  always_ff @(posedge clock) begin
    if (reset) begin
      a      <= '0;
      b      <= '0;
      opcode <= '0;
    end else if (ena && commit) begin
      a      <= a_p;
      b      <= b_p;
      opcode <= op_p;
    end
  end

  // Registered busy; trails the FSM states by one cycle.
  always_ff @(posedge clock) begin
    if (reset || !ena) busy <= 1'b0;
    else               busy <= byte_busy || (as_state != AS_HDR) || commit;
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at CLKS_PER_BIT = 8, TIMEOUT_BITS = 20.
module tb_uart_cmd_rx;
  localparam int CPB = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ena   = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] a, b;
  logic [2:0] opcode;
  logic       cmd_valid, frame_err, hdr_err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Strobe monitors (only written here; the stimulus takes snapshots).
  int cv_cnt = 0, fe_cnt = 0, he_cnt = 0, busy_hi = 0, wide = 0, cv_cyc = 0;
  logic cv_q = 1'b0, fe_q = 1'b0, he_q = 1'b0;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .clock     (clock),
    .reset     (reset),
    .ena       (ena),
    .rx        (rx),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err),
    .hdr_err   (hdr_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (cmd_valid === 1'b1) begin cv_cnt <= cv_cnt + 1; cv_cyc <= cyc; end
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (hdr_err === 1'b1)   he_cnt <= he_cnt + 1;
    if (busy === 1'b1)      busy_hi <= busy_hi + 1;
    if ((cmd_valid === 1'b1 && cv_q) || (frame_err === 1'b1 && fe_q) ||
        (hdr_err === 1'b1 && he_q))
      wide <= wide + 1;
    cv_q <= (cmd_valid === 1'b1);
    fe_q <= (frame_err === 1'b1);
    he_q <= (hdr_err === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    idle(CPB);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  int cv0, fe0, he0, bh0, nb;

  initial begin
    // Reset
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("rst_a", 32'(a), 0);
    chk("rst_b", 32'(b), 0);
    chk("rst_op", 32'(opcode), 0);
    chk("rst_cv", 32'(cmd_valid), 0);
    chk("rst_fe", 32'(frame_err), 0);
    chk("rst_he", 32'(hdr_err), 0);
    chk("rst_busy", 32'(busy), 0);
    bh0 = busy_hi;
    idle(50);
    chk("idle_busy", 32'(busy_hi - bh0), 0);

    // Good frame; cmd_valid expected 81 edges after B's start bit is driven
    cv0 = cv_cnt; fe0 = fe_cnt; he0 = he_cnt;
    send_byte(8'hA2, 1'b1);
    send_byte(8'h05, 1'b1);
    nb = cyc;
    send_byte(8'h03, 1'b1);
    idle(10);
    chk("good_cv", 32'(cv_cnt - cv0), 1);
    chk("good_lat", 32'(cv_cyc - nb), 81);
    chk("good_op", 32'(opcode), 2);
    chk("good_a", 32'(a), 32'h05);
    chk("good_b", 32'(b), 32'h03);
    chk("good_err", 32'((fe_cnt - fe0) + (he_cnt - he0)), 0);
    chk("good_busy", 32'(busy), 0);

    // Start glitch
    cv0 = cv_cnt; fe0 = fe_cnt; he0 = he_cnt;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(8);
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_strb", 32'((cv_cnt - cv0) + (fe_cnt - fe0) + (he_cnt - he0)), 0);
    send_byte(8'hA7, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(10);
    chk("glitch_cv", 32'(cv_cnt - cv0), 1);
    chk("glitch_op", 32'(opcode), 7);
    chk("glitch_a", 32'(a), 32'hFF);
    chk("glitch_b", 32'(b), 32'h00);

    // Bad stop bit mid-frame
    cv0 = cv_cnt; fe0 = fe_cnt; he0 = he_cnt;
    send_byte(8'hA1, 1'b1);
    send_byte(8'h10, 1'b0);
    rx = 1'b1;
    idle(20);
    chk("fe_cnt", 32'(fe_cnt - fe0), 1);
    chk("fe_cv", 32'(cv_cnt - cv0), 0);
    send_byte(8'hA1, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(10);
    chk("fe_after_cv", 32'(cv_cnt - cv0), 1);
    chk("fe_after_op", 32'(opcode), 1);
    chk("fe_after_a", 32'(a), 32'h22);
    chk("fe_after_b", 32'(b), 32'h33);
    chk("fe_after_he", 32'(he_cnt - he0), 0);

    // Bad header, then mid-frame timeout
    cv0 = cv_cnt; fe0 = fe_cnt; he0 = he_cnt;
    send_byte(8'h42, 1'b1);
    idle(3);
    chk("hdr_err", 32'(he_cnt - he0), 1);
    send_byte(8'hA3, 1'b1);
    idle(200);
    chk("to_busy", 32'(busy), 0);
    chk("to_strb", 32'((cv_cnt - cv0) + (fe_cnt - fe0) + (he_cnt - he0)), 1);
    send_byte(8'h11, 1'b1);
    idle(3);
    chk("to_hdr_err", 32'(he_cnt - he0), 2);
    chk("to_op_held", 32'(opcode), 1);

    // Reset during byte A's data bits
    cv0 = cv_cnt; he0 = he_cnt;
    send_byte(8'hA5, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("mid_rst_a", 32'(a), 0);
    chk("mid_rst_b", 32'(b), 0);
    chk("mid_rst_op", 32'(opcode), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    idle(30);
    send_byte(8'h12, 1'b1);
    idle(10);
    chk("mid_rst_cv", 32'(cv_cnt - cv0), 0);
    chk("mid_rst_he", 32'(he_cnt - he0), 1);

    // Enable dropped mid-frame holds outputs
    cv0 = cv_cnt; he0 = he_cnt;
    send_byte(8'hA6, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    idle(5);
    chk("ena_pre_cv", 32'(cv_cnt - cv0), 1);
    send_byte(8'hA4, 1'b1);
    send_byte(8'h77, 1'b1);
    ena = 1'b0;
    idle(3);
    chk("ena_busy", 32'(busy), 0);
    chk("ena_a", 32'(a), 32'h5A);
    chk("ena_b", 32'(b), 32'hC3);
    chk("ena_op", 32'(opcode), 6);
    ena = 1'b1;
    idle(5);
    send_byte(8'h99, 1'b1);
    idle(10);
    chk("ena_he", 32'(he_cnt - he0), 1);
    chk("ena_cv", 32'(cv_cnt - cv0), 1);

    chk("strobe_width", 32'(wide), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Receive side of the board's serial command link. It deserializes 8N1 UART bytes on `rx` and assembles 3-byte command frames (header/opcode, operand A, operand B). It presents `a`, `b` and `opcode` with a one-cycle `cmd_valid` strobe, in the form the ALU/FSM datapath consumes. It mirrors the existing UART transmit path, which returns ALU results in the opposite direction.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit. Must be at least 4.
- `TIMEOUT_BITS`, default 20: inter-byte timeout, in bit periods. It applies only mid-frame.

Ports:
- `clock`, input, 1: the single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `ena`, input, 1: block enable. Low forces idle.
- `rx`, input, 1: asynchronous serial line. Idle level is high.
- `a`, output, 8: operand A of the last accepted frame.
- `b`, output, 8: operand B of the last accepted frame.
- `opcode`, output, 3: opcode of the last accepted frame.
- `cmd_valid`, output, 1: one-cycle strobe. `a`, `b` and `opcode` are new in that cycle.
- `frame_err`, output, 1: one-cycle strobe on a bad stop bit.
- `hdr_err`, output, 1: one-cycle strobe on a bad header byte.
- `busy`, output, 1: high while a byte or a frame is in progress.

## Operation
- **Input sync:** `rx` passes through a 2-FF synchronizer. Both flops reset to 1. All logic uses the synchronized value `rxs`.
- **Byte receiver FSM** (states IDLE, START, DATA, STOP):
  - **IDLE:** a high-to-low transition of `rxs` moves to START and clears the bit counter.
  - **START:** sample at count `CLKS_PER_BIT/2 - 1` (integer division). If `rxs` = 1 it was a glitch: return to IDLE with no strobes. Otherwise go to DATA.
  - **DATA:** sample 8 bits, one every `CLKS_PER_BIT` cycles, LSB first, into a shift register.
  - **STOP:** sample once after a further `CLKS_PER_BIT` cycles.
    - `rxs` = 1: assert internal `byte_valid` for one cycle and go to IDLE.
    - `rxs` = 0: pulse `frame_err`, discard the byte, stay in STOP until `rxs` = 1, then go to IDLE.
- **Frame assembler FSM** (states HDR, OPA, OPB):
  - **HDR:** a byte with bits [7:3] = `CMD_TAG` (5'b10100) latches bits [2:0] as the pending opcode and moves to OPA. Any other byte pulses `hdr_err` and stays in HDR.
  - **OPA:** the byte is latched as pending A; move to OPB.
  - **OPB:** the byte is latched as pending B. On the next edge, `a`/`b`/`opcode` load the pending values, `cmd_valid` pulses, and the FSM returns to HDR.
  - `frame_err` in any state sends the assembler to HDR. Pending values are discarded.
  - **Timeout:** in OPA or OPB, a counter counts cycles since the last `byte_valid`. It reloads on every `byte_valid`. Reaching `TIMEOUT_BITS*CLKS_PER_BIT` returns the FSM to HDR silently, with no strobe.
- **Enable and reset:**
  - `ena` low: both FSMs go to IDLE/HDR, counters clear, strobes are 0. `a`, `b` and `opcode` hold their values.
  - `reset` overrides `ena`.
- **`busy`** = (byte FSM ≠ IDLE) OR (assembler ≠ HDR).

## Timing
- **Reset values:** `a` = 0, `b` = 0, `opcode` = 0, `cmd_valid` = 0, `frame_err` = 0, `hdr_err` = 0, `busy` = 0.
- **Sample points:** let t0 be the edge on which IDLE sees `rxs` fall. Then:
  - mid-start sample at t0 + `CLKS_PER_BIT/2`;
  - data bit i sampled at t0 + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`;
  - stop bit sampled at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- **Strobe latency:**
  - `byte_valid` and `frame_err` are high in the cycle after the stop sample.
  - `hdr_err` is high in the cycle after `byte_valid`.
  - `cmd_valid` is high 2 cycles after the stop sample of byte B.
  - Pin-to-output latency adds the 2 synchronizer cycles.
- **Outputs:** all outputs are registered, and no strobe is ever wider than one cycle.
- **Back-to-back bytes:** a start bit immediately after the stop bit must be accepted. IDLE is re-entered the cycle after the stop sample.
- **Simultaneous events:** a timeout and a `byte_valid` in the same cycle resolve in favour of the byte.
- **Reset mid-frame:** everything returns to the reset values on the next edge. A partially received frame is never emitted.

## Structure
- Package `uart_pkg` holds:
  - `CMD_TAG` = 5'b10100;
  - byte FSM state encodings (2 bits: IDLE, START, DATA, STOP);
  - assembler state encodings (2 bits: HDR, OPA, OPB).
- Sub-module `uart_rx_byte` contains the synchronizer and the byte FSM. Its outputs are `data[7:0]`, `byte_valid`, `frame_err` and `busy`.
- `uart_cmd_rx` contains the assembler, the timeout counter and the output registers.

## Test plan
Directed scenarios, all with `CLKS_PER_BIT` = 8 and `TIMEOUT_BITS` = 20:
- **Reset:** hold `reset` high for 3 cycles with `rx` = 1 → all outputs 0. `busy` stays 0 for 50 idle cycles.
- **Good frame:** send 0xA2, 0x05, 0x03 back-to-back → exactly one `cmd_valid`, 2 cycles after byte B's stop sample, with `opcode` = 2, `a` = 0x05, `b` = 0x03. No error strobes; `busy` returns to 0.
- **Start glitch:** pull `rx` low for 3 cycles → no strobes, `busy` is 0 again within 8 cycles. A following 0xA7, 0xFF, 0x00 gives `opcode` = 7, `a` = 0xFF, `b` = 0x00.
- **Bad stop bit:** send 0xA1, then 0x10 with a stop bit of 0 → one `frame_err` pulse and no `cmd_valid`. Then 0xA1, 0x22, 0x33 gives `opcode` = 1, `a` = 0x22, `b` = 0x33.
- **Bad header, then timeout:** send 0x42 → one `hdr_err` pulse. Then send 0xA3 and idle 200 cycles (≥160) → the assembler drops to HDR with no strobe. Then 0x11 gives `hdr_err`.
- **Reset and enable mid-frame:** assert `reset` during byte A's DATA state → outputs return to 0 and no `cmd_valid` follows. Separately, drop `ena` mid-frame → `busy` goes to 0 and the old `a`/`b`/`opcode` are held.
